// File: rtl/cpu_pkg.sv
// Shared definitions for the RISC control sequencer: state codes, opcodes, control vector.
// Build option CU_MULDIV_EN adds the mul/div instruction class.
package cpu_pkg;

   localparam int OP_W = 5;

   typedef logic [3:0] state_t;

   localparam state_t S_RESET = 4'd0;
   localparam state_t S_T0    = 4'd1;
   localparam state_t S_T1    = 4'd2;
   localparam state_t S_T2    = 4'd3;
   localparam state_t S_T3    = 4'd4;
   localparam state_t S_T4    = 4'd5;
   localparam state_t S_T5    = 4'd6;
   localparam state_t S_T6    = 4'd7;
   localparam state_t S_HALT  = 4'd8;

   localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
   localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
   localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
   localparam logic [OP_W-1:0] OP_SHL  = 5'b01000;
   localparam logic [OP_W-1:0] OP_ROR  = 5'b01001;
   localparam logic [OP_W-1:0] OP_ROL  = 5'b01010;
   localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
   localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
   localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
   localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
   localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

   typedef enum logic [2:0] {
      CLS_NOP,
      CLS_ALU,
      CLS_UNARY,
      CLS_MULDIV,
      CLS_HALT
   } op_class_e;

   typedef struct packed {
      logic            PCout;
      logic            Zhighout;
      logic            Zlowout;
      logic            MDRout;
      logic            HIout;
      logic            LOout;
      logic            PCin;
      logic            MARin;
      logic            MDRin;
      logic            IRin;
      logic            Yin;
      logic            Zin;
      logic            HIin;
      logic            LOin;
      logic            IncPC;
      logic            Read;
      logic            Gra;
      logic            Grb;
      logic            Grc;
      logic            Rin;
      logic            Rout;
      logic [OP_W-1:0] opcode;
   } ctrl_t;

   // Unknown opcodes fall into CLS_NOP so they retire after T3.
   function automatic op_class_e op_class(input logic [OP_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_SHR, OP_SHL, OP_ROR, OP_ROL: op_class = CLS_ALU;
         OP_NEG, OP_NOT:                 op_class = CLS_UNARY;
`ifdef CU_MULDIV_EN
         OP_MUL, OP_DIV:                 op_class = CLS_MULDIV;
         OP_NOP:                         op_class = CLS_NOP;
`else
         OP_MUL, OP_DIV, OP_NOP:         op_class = CLS_NOP;
`endif
         OP_HALT:                        op_class = CLS_HALT;
         default:                        op_class = CLS_NOP;
      endcase
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bus between the sequencer (master) and the datapath (slave).
interface control_unit_if #(
   parameter int WORD_W = 32,
   parameter int OP_W   = 5
);
   logic [WORD_W-1:0] IR;
   logic              Mem_ready;
   logic              Stop;
   logic              PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
   logic              PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin;
   logic              IncPC, Read;
   logic              Gra, Grb, Grc, Rin, Rout;
   logic [OP_W-1:0]   opcode;
   logic              Run;

   modport master (
      input  IR, Mem_ready, Stop,
      output PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
             PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
             IncPC, Read, Gra, Grb, Grc, Rin, Rout, opcode, Run
   );

   modport slave (
      output IR, Mem_ready, Stop,
      input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
             PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
             IncPC, Read, Gra, Grb, Grc, Rin, Rout, opcode, Run
   );
endinterface

// File: rtl/cu_decode.sv
// Combinational map from (state, T1 wait flag, latched opcode) to the control vector.
// Build option CU_MULDIV_EN adds the mul/div T3-T6 strobes.
module cu_decode
   import cpu_pkg::*;
(
   input  state_t          state_i,
   input  logic            t1_wait_i,
   input  logic [OP_W-1:0] op_i,
   output ctrl_t           ctrl_o
);

   op_class_e cls;

   always_comb begin
      cls    = op_class(op_i);
      ctrl_o = '0;
      case (state_i)
         S_T0: begin
            ctrl_o.PCout = 1'b1;
            ctrl_o.MARin = 1'b1;
            ctrl_o.IncPC = 1'b1;
            ctrl_o.Zin   = 1'b1;
         end
         S_T1: begin
            ctrl_o.Read  = 1'b1;
            ctrl_o.MDRin = 1'b1;
            // PC write-back happens once; wait cycles only re-strobe the read.
            if (!t1_wait_i) begin
               ctrl_o.Zlowout = 1'b1;
               ctrl_o.PCin    = 1'b1;
            end
         end
         S_T2: begin
            ctrl_o.MDRout = 1'b1;
            ctrl_o.IRin   = 1'b1;
         end
         S_T3: begin
            case (cls)
               CLS_ALU: begin
                  ctrl_o.Grb  = 1'b1;
                  ctrl_o.Rout = 1'b1;
                  ctrl_o.Yin  = 1'b1;
               end
               CLS_UNARY: begin
                  ctrl_o.Grb    = 1'b1;
                  ctrl_o.Rout   = 1'b1;
                  ctrl_o.opcode = op_i;
                  ctrl_o.Zin    = 1'b1;
               end
`ifdef CU_MULDIV_EN
               CLS_MULDIV: begin
                  ctrl_o.Gra  = 1'b1;
                  ctrl_o.Rout = 1'b1;
                  ctrl_o.Yin  = 1'b1;
               end
`endif
               default: ;
            endcase
         end
         S_T4: begin
            case (cls)
               CLS_ALU: begin
                  ctrl_o.Grc    = 1'b1;
                  ctrl_o.Rout   = 1'b1;
                  ctrl_o.opcode = op_i;
                  ctrl_o.Zin    = 1'b1;
               end
               CLS_UNARY: begin
                  ctrl_o.Zlowout = 1'b1;
                  ctrl_o.Gra     = 1'b1;
                  ctrl_o.Rin     = 1'b1;
               end
`ifdef CU_MULDIV_EN
               CLS_MULDIV: begin
                  ctrl_o.Grb    = 1'b1;
                  ctrl_o.Rout   = 1'b1;
                  ctrl_o.opcode = op_i;
                  ctrl_o.Zin    = 1'b1;
               end
`endif
               default: ;
            endcase
         end
         S_T5: begin
            if (cls == CLS_ALU) begin
               ctrl_o.Zlowout = 1'b1;
               ctrl_o.Gra     = 1'b1;
               ctrl_o.Rin     = 1'b1;
            end
`ifdef CU_MULDIV_EN
            if (cls == CLS_MULDIV) begin
               ctrl_o.Zlowout = 1'b1;
               ctrl_o.LOin    = 1'b1;
            end
`endif
         end
`ifdef CU_MULDIV_EN
         S_T6: begin
            ctrl_o.Zhighout = 1'b1;
            ctrl_o.HIin     = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer: state register, latched opcode, registered control outputs.
// Build option CU_MULDIV_EN enables mul/div (T6, HIin, LOin).
module control_unit #(
   parameter int WORD_W = 32,
   parameter int OP_W   = 5
) (
   input logic            Clock,
   input logic            clear,
   control_unit_if.master bus
);

   cpu_pkg::state_t    state_q, state_d;
   logic [OP_W-1:0]    op_q, op_d;
   logic               t1_wait_q, t1_wait_d;
   cpu_pkg::ctrl_t     ctrl_q, ctrl_d;
   logic               run_q, run_d;
   cpu_pkg::op_class_e cls;
   logic               instr_done;

   always_comb begin
      cls        = cpu_pkg::op_class(op_q);
      state_d    = state_q;
      op_d       = op_q;
      t1_wait_d  = 1'b0;
      instr_done = 1'b0;
      case (state_q)
         cpu_pkg::S_RESET: state_d = cpu_pkg::S_T0;
         cpu_pkg::S_T0:    state_d = cpu_pkg::S_T1;
         cpu_pkg::S_T1: begin
            if (bus.Mem_ready) begin
               state_d = cpu_pkg::S_T2;
            end else begin
               t1_wait_d = 1'b1;
            end
         end
         cpu_pkg::S_T2: begin
            state_d = cpu_pkg::S_T3;
            op_d    = bus.IR[WORD_W-1 -: OP_W];
         end
         cpu_pkg::S_T3: begin
            case (cls)
               cpu_pkg::CLS_ALU,
               cpu_pkg::CLS_UNARY,
               cpu_pkg::CLS_MULDIV: state_d = cpu_pkg::S_T4;
               cpu_pkg::CLS_HALT:   state_d = cpu_pkg::S_HALT;
               default:             instr_done = 1'b1;
            endcase
         end
         cpu_pkg::S_T4: begin
            if (cls == cpu_pkg::CLS_ALU || cls == cpu_pkg::CLS_MULDIV) begin
               state_d = cpu_pkg::S_T5;
            end else begin
               instr_done = 1'b1;
            end
         end
         cpu_pkg::S_T5: begin
`ifdef CU_MULDIV_EN
            if (cls == cpu_pkg::CLS_MULDIV) begin
               state_d = cpu_pkg::S_T6;
            end else begin
               instr_done = 1'b1;
            end
`else
            instr_done = 1'b1;
`endif
         end
         cpu_pkg::S_T6:   instr_done = 1'b1;
         cpu_pkg::S_HALT: state_d = cpu_pkg::S_HALT;
         default:         state_d = cpu_pkg::S_RESET;
      endcase
      // Stop is honoured only when the instruction retires.
      if (instr_done) begin
         state_d = bus.Stop ? cpu_pkg::S_HALT : cpu_pkg::S_T0;
      end
      run_d = (state_d != cpu_pkg::S_RESET) && (state_d != cpu_pkg::S_HALT);
   end

   // Decoding the next state lets the output register line up with state_q.
   cu_decode u_decode (
      .state_i   (state_d),
      .t1_wait_i (t1_wait_d),
      .op_i      (op_d),
      .ctrl_o    (ctrl_d)
   );

   always_ff @(posedge Clock) begin
      if (!clear) begin
         state_q   <= cpu_pkg::S_RESET;
         op_q      <= '0;
         t1_wait_q <= 1'b0;
         ctrl_q    <= '0;
         run_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         t1_wait_q <= t1_wait_d;
         ctrl_q    <= ctrl_d;
         run_q     <= run_d;
      end
   end

   assign bus.PCout    = ctrl_q.PCout;
   assign bus.Zhighout = ctrl_q.Zhighout;
   assign bus.Zlowout  = ctrl_q.Zlowout;
   assign bus.MDRout   = ctrl_q.MDRout;
   assign bus.HIout    = ctrl_q.HIout;
   assign bus.LOout    = ctrl_q.LOout;
   assign bus.PCin     = ctrl_q.PCin;
   assign bus.MARin    = ctrl_q.MARin;
   assign bus.MDRin    = ctrl_q.MDRin;
   assign bus.IRin     = ctrl_q.IRin;
   assign bus.Yin      = ctrl_q.Yin;
   assign bus.Zin      = ctrl_q.Zin;
   assign bus.IncPC    = ctrl_q.IncPC;
   assign bus.Read     = ctrl_q.Read;
   assign bus.Gra      = ctrl_q.Gra;
   assign bus.Grb      = ctrl_q.Grb;
   assign bus.Grc      = ctrl_q.Grc;
   assign bus.Rin      = ctrl_q.Rin;
   assign bus.Rout     = ctrl_q.Rout;
   assign bus.opcode   = ctrl_q.opcode;
   assign bus.Run      = run_q;

   logic unused_bits;
`ifdef CU_MULDIV_EN
   assign bus.HIin  = ctrl_q.HIin;
   assign bus.LOin  = ctrl_q.LOin;
   assign unused_bits = ^{bus.IR[WORD_W-OP_W-1:0], t1_wait_q};
`else
   assign bus.HIin  = 1'b0;
   assign bus.LOin  = 1'b0;
   assign unused_bits = ^{bus.IR[WORD_W-OP_W-1:0], t1_wait_q, ctrl_q.HIin, ctrl_q.LOin};
`endif

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected control words from an instruction-level model.
module tb_control_unit;

   logic Clock = 1'b0;
   logic clear;
   always #5 Clock = ~Clock;

   control_unit_if #(.WORD_W(32), .OP_W(5)) bus ();

   control_unit #(.WORD_W(32), .OP_W(5)) dut (
      .Clock (Clock),
      .clear (clear),
      .bus   (bus)
   );

   localparam logic [26:0] V_RUN      = 27'h1 << 26;
   localparam logic [26:0] V_PCOUT    = 27'h1 << 25;
   localparam logic [26:0] V_ZHIGHOUT = 27'h1 << 24;
   localparam logic [26:0] V_ZLOWOUT  = 27'h1 << 23;
   localparam logic [26:0] V_MDROUT   = 27'h1 << 22;
   localparam logic [26:0] V_PCIN     = 27'h1 << 19;
   localparam logic [26:0] V_MARIN    = 27'h1 << 18;
   localparam logic [26:0] V_MDRIN    = 27'h1 << 17;
   localparam logic [26:0] V_IRIN     = 27'h1 << 16;
   localparam logic [26:0] V_YIN      = 27'h1 << 15;
   localparam logic [26:0] V_ZIN      = 27'h1 << 14;
   localparam logic [26:0] V_HIIN     = 27'h1 << 13;
   localparam logic [26:0] V_LOIN     = 27'h1 << 12;
   localparam logic [26:0] V_INCPC    = 27'h1 << 11;
   localparam logic [26:0] V_READ     = 27'h1 << 10;
   localparam logic [26:0] V_GRA      = 27'h1 << 9;
   localparam logic [26:0] V_GRB      = 27'h1 << 8;
   localparam logic [26:0] V_GRC      = 27'h1 << 7;
   localparam logic [26:0] V_RIN      = 27'h1 << 6;
   localparam logic [26:0] V_ROUT     = 27'h1 << 5;

   localparam logic [26:0] V_T0  = V_RUN | V_PCOUT | V_MARIN | V_INCPC | V_ZIN;
   localparam logic [26:0] V_T1  = V_RUN | V_ZLOWOUT | V_PCIN | V_READ | V_MDRIN;
   localparam logic [26:0] V_T1W = V_RUN | V_READ | V_MDRIN;
   localparam logic [26:0] V_T2  = V_RUN | V_MDROUT | V_IRIN;

   logic [26:0] act_vec;
   logic [26:0] exp_v;
   logic [26:0] exp_q[$];
   int          vectors     = 0;
   int          miscompares = 0;

   assign act_vec = {bus.Run, bus.PCout, bus.Zhighout, bus.Zlowout, bus.MDRout, bus.HIout,
                     bus.LOout, bus.PCin, bus.MARin, bus.MDRin, bus.IRin, bus.Yin, bus.Zin,
                     bus.HIin, bus.LOin, bus.IncPC, bus.Read, bus.Gra, bus.Grb, bus.Grc,
                     bus.Rin, bus.Rout, bus.opcode};

   // Monitor: one expected control word per displayed cycle.
   always @(negedge Clock) begin
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         vectors++;
         if (act_vec !== exp_v) begin
            miscompares++;
            $display("FAIL ctrl_word t=%0t: got %07h expected %07h", $time, act_vec, exp_v);
         end
      end
   end

   // Instruction kind: 0 nop, 1 binary ALU, 2 unary, 3 mul/div, 4 halt.
   function automatic int kind(input logic [4:0] op);
      int v;
      v = int'(op);
      if (v >= 3 && v <= 10) return 1;
      if (v == 17 || v == 18) return 2;
`ifdef CU_MULDIV_EN
      if (v == 15 || v == 16) return 3;
`endif
      if (v == 27) return 4;
      return 0;
   endfunction

   task automatic step(input logic [26:0] e, input logic mr, input logic st,
                       input logic [31:0] ir, input logic clr);
      @(posedge Clock);
      #1;
      exp_q.push_back(e);
      bus.Mem_ready = mr;
      bus.Stop      = st;
      bus.IR        = ir;
      clear         = clr;
   endtask

   task automatic run_instr(input logic [31:0] instr, input int waits, input logic stop_end,
                            input int abort_at, output logic halted);
      logic [26:0] seq[$];
      logic [26:0] opv;
      logic [4:0]  op;
      int          k;
      logic        mr;
      logic        st;
      logic [31:0] ir;
      op  = instr[31:27];
      opv = {22'b0, op};
      k   = kind(op);
      seq = {};
      seq.push_back(V_T0);
      seq.push_back(V_T1);
      repeat (waits) seq.push_back(V_T1W);
      seq.push_back(V_T2);
      case (k)
         1: begin
            seq.push_back(V_RUN | V_GRB | V_ROUT | V_YIN);
            seq.push_back(V_RUN | V_GRC | V_ROUT | V_ZIN | opv);
            seq.push_back(V_RUN | V_ZLOWOUT | V_GRA | V_RIN);
         end
         2: begin
            seq.push_back(V_RUN | V_GRB | V_ROUT | V_ZIN | opv);
            seq.push_back(V_RUN | V_ZLOWOUT | V_GRA | V_RIN);
         end
         3: begin
            seq.push_back(V_RUN | V_GRA | V_ROUT | V_YIN);
            seq.push_back(V_RUN | V_GRB | V_ROUT | V_ZIN | opv);
            seq.push_back(V_RUN | V_ZLOWOUT | V_LOIN);
            seq.push_back(V_RUN | V_ZHIGHOUT | V_HIIN);
         end
         default: seq.push_back(V_RUN);
      endcase
      halted = (k == 4) || stop_end;
      for (int i = 0; i < seq.size(); i++) begin
         mr = 1'($urandom_range(0, 1));
         if (i >= 1 && i <= 1 + waits) mr = (i == 1 + waits);
         ir = (i == 2 + waits) ? instr : $urandom;
         st = (i == seq.size() - 1) ? stop_end : 1'($urandom_range(0, 1));
         step(seq[i], mr, st, ir, (i == abort_at) ? 1'b0 : 1'b1);
         if (i == abort_at) begin
            step(27'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'b1);
            halted = 1'b0;
            return;
         end
      end
   endtask

   task automatic halt_phase(input int n);
      repeat (n) step(27'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'b1);
      step(27'h0, 1'b0, 1'b0, $urandom, 1'b0);
      step(27'h0, 1'b0, 1'b0, $urandom, 1'b1);
   endtask

   logic [4:0] known_ops[14] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                  5'd15, 5'd16, 5'd17, 5'd18, 5'd26, 5'd27};

   initial begin
      logic        h;
      logic [4:0]  rop;
      int          ab;
      bus.Mem_ready = 1'b0;
      bus.Stop      = 1'b0;
      bus.IR        = '0;
      clear         = 1'b0;

      step(27'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      step(27'h0, 1'b1, 1'b0, 32'h0, 1'b1);

      run_instr(32'h28918000, 0, 1'b0, -1, h);                  // and
      run_instr(32'h80000000, 0, 1'b0, -1, h);                  // div
      run_instr(32'h18000000 | ($urandom & 32'h07ffffff), 3, 1'b0, -1, h);
      run_instr(32'h88000000, 1, 1'b0, -1, h);                  // neg
      run_instr(32'hD8000000, 0, 1'b0, -1, h);                  // halt
      if (h) halt_phase(20);
      run_instr(32'h18918000, 0, 1'b0, 4, h);                   // add aborted in T4
      run_instr(32'h18918000, 0, 1'b1, -1, h);                  // add with Stop in T5
      if (h) halt_phase(5);

      for (int n = 0; n < 120; n++) begin
         rop = ($urandom_range(0, 3) == 0) ? 5'($urandom) : known_ops[$urandom_range(0, 13)];
         ab  = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 9) : -1;
         run_instr({rop, 27'($urandom)}, $urandom_range(0, 3), ($urandom_range(0, 9) == 0), ab, h);
         if (h) halt_phase($urandom_range(1, 4));
      end

      @(negedge Clock);
      #1;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
